// File: rtl/shiftregister_piso_pkg.sv
// rtl/shiftregister_piso_pkg.sv - shared width default and word type for the PISO shifter and its producers
package shiftregister_piso_pkg;

  localparam int PISO_WIDTH_DEFAULT = 4;

  typedef logic [PISO_WIDTH_DEFAULT-1:0] piso_word_t;

endpackage : shiftregister_piso_pkg

// File: rtl/shiftregister_piso_if.sv
// rtl/shiftregister_piso_if.sv - parallel word / load / serial bit bundle between producer and PISO shifter
interface shiftregister_piso_if
  import shiftregister_piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] Parallel_In;
  logic             load;
  logic             Serial_Out;

  modport master (
    output Parallel_In,
    output load,
    input  Serial_Out
  );

  modport slave (
    input  Parallel_In,
    input  load,
    output Serial_Out
  );

endinterface : shiftregister_piso_if

// File: rtl/shiftregister_piso.sv
// rtl/shiftregister_piso.sv - parallel-in serial-out shift register, MSB first unless PISO_LSB_FIRST_EN is defined
module shiftregister_piso
  import shiftregister_piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst_n,
  shiftregister_piso_if.slave bus
);

  logic [WIDTH-1:0] sr;

  // A load always wins, discarding whatever is still being shifted out.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr <= '0;
    end else if (bus.load) begin
      sr <= bus.Parallel_In;
    end else begin
`ifdef PISO_LSB_FIRST_EN
      sr <= {1'b0, sr[WIDTH-1:1]};
`else
      sr <= {sr[WIDTH-2:0], 1'b0};
`endif
    end
  end

`ifdef PISO_LSB_FIRST_EN
  assign bus.Serial_Out = sr[0];
`else
  assign bus.Serial_Out = sr[WIDTH-1];
`endif

endmodule : shiftregister_piso

// File: tb/tb_shiftregister_piso.sv
// tb/tb_shiftregister_piso.sv - self-checking bench for shiftregister_piso at WIDTH 4 and 8
module tb_shiftregister_piso;
  import shiftregister_piso_pkg::*;

`ifdef PISO_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst_n;

  always #5 Clk = ~Clk;

  shiftregister_piso_if #(.WIDTH(4)) bus4 ();
  shiftregister_piso_if #(.WIDTH(8)) bus8 ();

  shiftregister_piso #(.WIDTH(4)) dut4 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus4.slave));
  shiftregister_piso #(.WIDTH(8)) dut8 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus8.slave));

  typedef struct {
    logic       ld;
    piso_word_t pin;
    logic       exp;
    string      name;
  } vec_t;

  typedef struct {
    logic  exp;
    string name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: Serial_Out=%b expected %b", name, act, exp);
    end
  endtask

  task automatic pop_check(input logic act);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: no expected entry, Serial_Out=%b", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  task automatic drive4(input logic ld, input piso_word_t pin, input logic exp, input string name);
    bus4.load        = ld;
    bus4.Parallel_In = pin;
    @(posedge Clk);
    sb_q.push_back('{exp, name});
    @(negedge Clk);
    pop_check(bus4.Serial_Out);
  endtask

  task automatic drive8(input logic ld, input logic [7:0] pin, input logic exp, input string name);
    bus8.load        = ld;
    bus8.Parallel_In = pin;
    @(posedge Clk);
    sb_q.push_back('{exp, name});
    @(negedge Clk);
    pop_check(bus8.Serial_Out);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w8;

    vecs.push_back('{1'b1, 4'b1010, LSB ? 1'b0 : 1'b1, "cons_load_1010"});
    vecs.push_back('{1'b1, 4'b1100, LSB ? 1'b0 : 1'b1, "cons_load_1100"});
    vecs.push_back('{1'b1, 4'b1111, 1'b1,              "cons_load_1111"});
    vecs.push_back('{1'b1, 4'b0101, LSB ? 1'b1 : 1'b0, "cons_load_0101"});
    vecs.push_back('{1'b0, 4'b0000, LSB ? 1'b0 : 1'b1, "shift0101_1"});
    vecs.push_back('{1'b0, 4'b0000, LSB ? 1'b1 : 1'b0, "shift0101_2"});
    vecs.push_back('{1'b0, 4'b0000, LSB ? 1'b0 : 1'b1, "shift0101_3"});
    vecs.push_back('{1'b0, 4'b0000, 1'b0,              "shift0101_4"});
    vecs.push_back('{1'b0, 4'b0000, 1'b0,              "zero_fill"});
    vecs.push_back('{1'b1, 4'b1000, LSB ? 1'b0 : 1'b1, "load_1000"});
    vecs.push_back('{1'b0, 4'b1111, 1'b0,              "mid_shift"});
    vecs.push_back('{1'b1, 4'b0001, LSB ? 1'b1 : 1'b0, "reload_0001"});
    vecs.push_back('{1'b0, 4'b0000, 1'b0,              "reload_shift1"});
    vecs.push_back('{1'b0, 4'b0000, 1'b0,              "reload_shift2"});
    vecs.push_back('{1'b0, 4'b0000, LSB ? 1'b0 : 1'b1, "reload_shift3"});
    vecs.push_back('{1'b1, 4'b0110, 1'b0,              "load_0110"});
    vecs.push_back('{1'b0, 4'b0000, 1'b1,              "shift0110_1"});
    vecs.push_back('{1'b0, 4'b0000, 1'b1,              "shift0110_2"});
    vecs.push_back('{1'b0, 4'b0000, 1'b0,              "shift0110_3"});
    vecs.push_back('{1'b0, 4'b0000, 1'b0,              "shift0110_4"});

    Rst_n            = 1'b0;
    bus4.load        = 1'b0;
    bus4.Parallel_In = '0;
    bus8.load        = 1'b0;
    bus8.Parallel_In = '0;
    #12;
    check("reset_state4", bus4.Serial_Out, 1'b0);
    check("reset_state8", bus8.Serial_Out, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;

    foreach (vecs[i]) drive4(vecs[i].ld, vecs[i].pin, vecs[i].exp, vecs[i].name);

    // Asynchronous reset with a full register, checked before the next clock edge
    drive4(1'b1, 4'b1111, 1'b1, "rst_preload");
    bus4.load = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    check("rst_async", bus4.Serial_Out, 1'b0);
    @(negedge Clk);
    check("rst_hold", bus4.Serial_Out, 1'b0);
    Rst_n = 1'b1;
    drive4(1'b0, 4'b0000, 1'b0, "rst_release1");
    drive4(1'b0, 4'b0000, 1'b0, "rst_release2");

    // Width 8: A5 is a bit palindrome, so both shift directions give the same stream
    w8 = 8'hA5;
    drive8(1'b1, w8, 1'b1, "w8_load");
    drive8(1'b0, 8'h00, 1'b0, "w8_bit1");
    drive8(1'b0, 8'h00, 1'b1, "w8_bit2");
    drive8(1'b0, 8'h00, 1'b0, "w8_bit3");
    drive8(1'b0, 8'h00, 1'b0, "w8_bit4");
    drive8(1'b0, 8'h00, 1'b1, "w8_bit5");
    drive8(1'b0, 8'h00, 1'b0, "w8_bit6");
    drive8(1'b0, 8'h00, 1'b1, "w8_bit7");
    drive8(1'b0, 8'h00, 1'b0, "w8_zero_fill");

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shiftregister_piso

// File: doc/shiftregister_piso.md
# shiftregister_piso

Parallel-in, serial-out shift register. A `WIDTH`-bit word is captured on a load cycle. It is then shifted out one bit per clock on `Serial_Out`, MSB first by default. The block sits at the edge of a serial transmit path, where a producer hands over whole words and a downstream serial link consumes the bit stream.

## Interface
- `WIDTH`, default 4: width of the parallel word and of the internal shift register; legal range 2..64.
- `Clk`  input  1  single clock; all state updates on the rising edge.
- `Rst_n`  input  1  asynchronous, active-low reset.
- `Parallel_In`  input  WIDTH  word captured when `load` is high at a rising edge.
- `load`  input  1  1 = parallel load, 0 = shift.
- `Serial_Out`  output  1  current output bit; driven directly from the shift-register output end.

## Operation
- Internal state: register `sr[WIDTH-1:0]`; no other state.
- Reset (`Rst_n` = 0): `sr` cleared to all zeros immediately, without waiting for a clock; `Serial_Out` = 0 while in reset.
- Rising edge with `load` = 1: `sr <= Parallel_In`; any bits still being shifted are discarded; no handshake or busy check.
- Rising edge with `load` = 0:
  - MSB-first: `sr <= {sr[WIDTH-2:0], 1'b0}`.
  - Zero fill: after WIDTH shift cycles `Serial_Out` stays 0 until the next load.
- Output bit:
  - MSB-first: `Serial_Out = sr[WIDTH-1]`.
  - LSB-first (see Configuration): `Serial_Out = sr[0]`.
  - No combinational path from `Parallel_In` or `load` to `Serial_Out`.
- Back-to-back loads: each load overwrites `sr`. Only the last loaded word is shifted after `load` falls.
- Reset deasserted mid-stream: the register restarts from all zeros; a new load is required.

## Timing
- Load-to-output latency: the first bit of a loaded word appears on `Serial_Out` immediately after the loading edge, with 1 cycle of latency.
- Bit k (k = 0..WIDTH-1, counting from the first bit out) is valid during the cycle after the k-th shift edge that follows the load edge.
- A full word occupies exactly WIDTH consecutive output cycles (load cycle plus WIDTH-1 shifts).
- Reset assertion is asynchronous. Deassertion is synchronised externally, and the block requires no recovery cycles.

## Configuration
- `PISO_LSB_FIRST_EN`
  - Defined: shift direction reversed, `sr <= {1'b0, sr[WIDTH-1:1]}` and `Serial_Out = sr[0]`. LSB is transmitted first, zero fill enters at the MSB.
  - Undefined (default): MSB-first behaviour described above.
- Load and reset behaviour are identical in both builds.

## Structure
- Shared package `shiftregister_piso_pkg`: `PISO_WIDTH_DEFAULT = 4` and a typedef `piso_word_t` = logic [PISO_WIDTH_DEFAULT-1:0] for benches and producers.
- No sub-module: one sequential process for `sr` and one continuous assignment for `Serial_Out`.

## Test plan
- Reset: assert `Rst_n` = 0 mid-cycle with `sr` = 4'b1111 -> `Serial_Out` goes 0 immediately, before any clock edge; stays 0 after release with `load` = 0.
- Consecutive loads: `load` = 1 with `Parallel_In` = 1010, 1100, 1111, 0101 on four successive edges -> `Serial_Out` = 1, 1, 1, 0 after each edge.
- Shift-out: after loading 0101, hold `load` = 0 for 5 edges -> `Serial_Out` = 1, 0, 1, 0, 0 (zero fill thereafter).
- Load during shift: load 1000, shift 1 edge, then load 0001 -> `Serial_Out` 1, 0, then 0 on the reload edge; three more shifts give 0, 0, 1.
- LSB-first build (`PISO_LSB_FIRST_EN` defined): load 0110, then 4 shifts -> `Serial_Out` 0 after load, then 1, 1, 0, 0.
- Width sweep: `WIDTH` = 8, load 8'hA5 then 7 shifts -> MSB-first `Serial_Out` sequence 1,0,1,0,0,1,0,1, then 0.
